// File: rtl/sseg_pkg.sv
// Shared types and the active-low hex glyph table for the seven-segment scan driver.
package sseg_pkg;

    typedef logic [3:0] nibble_t;
    typedef nibble_t [3:0] digits_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment (common-anode panel).
    function automatic logic [6:0] hex_to_seg(input nibble_t nib);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sseg_decoder.sv
// Combinational nibble-to-glyph decoder; thin wrapper around hex_to_seg.
module sseg_decoder
    import sseg_pkg::*;
(
    input  nibble_t    i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = hex_to_seg(i_nibble);

endmodule

// File: rtl/sseg_scan_driver.sv
// Four-digit common-anode scan driver with tear-free shadow latch and anti-ghost blanking.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 always shown).
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100_000,
    parameter int BLANK_CYCLES = 1_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_mask,
    output logic [6:0]  Seg,
    output logic [3:0]  an,
    output logic        dp
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    digits_t          r_shadowDigits;
    logic [3:0]       r_shadowDp;
    logic [6:0]       r_seg;
    logic [3:0]       r_an;
    logic             r_dp;

    nibble_t          w_curDigit;
    logic [6:0]       w_glyph;
    logic             w_blank;
    logic             w_suppress;

    // Slot timing, digit index and the once-per-scan shadow capture of the live inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt          <= '0;
            r_idx          <= 2'd0;
            r_shadowDigits <= '0;
            r_shadowDp     <= 4'h0;
        end else begin
            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if ((r_cnt == '0) && (r_idx == 2'd0)) begin
                r_shadowDigits <= digits;
                r_shadowDp     <= dp_mask;
            end
        end
    end

    assign w_curDigit = r_shadowDigits[r_idx];

    sseg_decoder u_decoder (
        .i_nibble (w_curDigit),
        .o_seg    (w_glyph)
    );

    generate
        if (BLANK_CYCLES == 0) begin : g_noBlank
            assign w_blank = 1'b0;
        end else begin : g_blank
            assign w_blank = (r_cnt < CNT_W'(BLANK_CYCLES));
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every digit to its left are zero.
    always_comb begin
        w_suppress = 1'b0;
        case (r_idx)
            2'd3: w_suppress = (r_shadowDigits[3] == 4'h0);
            2'd2: w_suppress = (r_shadowDigits[3] == 4'h0) && (r_shadowDigits[2] == 4'h0);
            2'd1: w_suppress = (r_shadowDigits[3] == 4'h0) && (r_shadowDigits[2] == 4'h0)
                               && (r_shadowDigits[1] == 4'h0);
            default: w_suppress = 1'b0;
        endcase
    end
`else
    assign w_suppress = 1'b0;
`endif

    // Registered pins keep the panel glitch-free; segment data follows idx even while blanked.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg <= SEG_BLANK;
            r_an  <= 4'hF;
            r_dp  <= 1'b1;
        end else begin
            r_seg <= w_suppress ? SEG_BLANK : w_glyph;
            r_an  <= w_blank ? 4'hF : ~(4'b0001 << r_idx);
            r_dp  <= ~r_shadowDp[r_idx];
        end
    end

    assign Seg = r_seg;
    assign an  = r_an;
    assign dp  = r_dp;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Randomized self-checking bench for sseg_scan_driver against a time-based reference model.
module tb_sseg_scan_driver;

    localparam int RD = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] digits = 16'h0000;
    logic [3:0]  dp_mask = 4'h0;
    logic [6:0]  Seg;
    logic [3:0]  an;
    logic        dp;

    int total = 0;
    int bad = 0;

    int          edgeCount;
    logic [15:0] modelDigits;
    logic [3:0]  modelDp;
    logic [6:0]  expSeg;
    logic [3:0]  expAn;
    logic        expDp;

    // Active-high segment sets {g..a} per hex value; the panel wants the inverse.
    logic [6:0] litSegs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;

    sseg_scan_driver #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .digits  (digits),
        .dp_mask (dp_mask),
        .Seg     (Seg),
        .an      (an),
        .dp      (dp)
    );

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference model: position in the scan is derived purely from edges elapsed since reset.
    initial begin
        int          slotPos;
        int          slotIdx;
        logic [3:0]  digit;
        edgeCount   = 0;
        modelDigits = 16'h0000;
        modelDp     = 4'h0;
        forever begin
            @(posedge clk);
            if (reset) begin
                expSeg      = 7'h7F;
                expAn       = 4'hF;
                expDp       = 1'b1;
                edgeCount   = 0;
                modelDigits = 16'h0000;
                modelDp     = 4'h0;
            end else begin
                slotPos = edgeCount % RD;
                slotIdx = (edgeCount / RD) % 4;
                expAn   = (slotPos < BC) ? 4'hF : (4'hF ^ (4'd1 << slotIdx));
                digit   = 4'(modelDigits >> (4 * slotIdx));
                expSeg  = ~litSegs[digit];
`ifdef LEADING_ZERO_BLANK_EN
                if ((slotIdx != 0) && ((modelDigits >> (4 * slotIdx)) == 16'h0000))
                    expSeg = 7'h7F;
`endif
                expDp = ~modelDp[slotIdx];
                if (edgeCount % (4 * RD) == 0) begin
                    modelDigits = digits;
                    modelDp     = dp_mask;
                end
                edgeCount++;
            end
            #1;
            checkOutput("seg", 16'(Seg), 16'(expSeg));
            checkOutput("an", 16'(an), 16'(expAn));
            checkOutput("dp", 16'(dp), 16'(expDp));
        end
    end

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] m, input logic r,
                                 input int cycles);
        digits  = d;
        dp_mask = m;
        reset   = r;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic waitSlotPos(input int idx, input int cnt);
        int target;
        int tries;
        target = idx * RD + cnt;
        tries  = 0;
        while (((edgeCount % (4 * RD)) != target) && (tries < 8 * RD)) begin
            @(negedge clk);
            tries++;
        end
        checkOutput("waitSlot", 16'(edgeCount % (4 * RD)), 16'(target));
    endtask

    function automatic logic [15:0] randDigits();
        logic [15:0] v;
        v = 16'($urandom);
        for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 1) == 0) v[4*i +: 4] = 4'h0;
        return v;
    endfunction

    initial begin
        @(negedge clk);
        applyStimulus(16'h1234, 4'h0, 1'b1, 3);
        applyStimulus(16'h1234, 4'h0, 1'b0, 70);
        waitSlotPos(2, 0);
        applyStimulus(16'h5678, 4'h0, 1'b0, 45);
        applyStimulus(16'h5678, 4'b0100, 1'b0, 70);
        waitSlotPos(2, 5);
        applyStimulus(16'h5678, 4'b0100, 1'b1, 1);
        applyStimulus(16'h5678, 4'b0100, 1'b0, 45);
        applyStimulus(16'h0040, 4'h0, 1'b0, 70);
        applyStimulus(16'h0000, 4'h1, 1'b0, 70);
        applyStimulus(16'hABCD, 4'hF, 1'b0, 70);
        applyStimulus(16'h0EF9, 4'h5, 1'b0, 70);
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 19) == 0)
                applyStimulus(randDigits(), 4'($urandom), 1'b1, $urandom_range(1, 2));
            else
                applyStimulus(randDigits(), 4'($urandom), 1'b0, $urandom_range(1, 40));
        end
        applyStimulus(16'h0000, 4'h0, 1'b0, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
